memory_bus_ctrl: RTL and testbench
==================================

MEMORY_BUS_CTRL -- requirements
Module: memory_bus_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  DATA_W, 16, bus data width.
  RAM_WAIT, 1, extra wait cycles for RAM access (0..15).
  ROM_WAIT, 0, extra wait cycles for ROM access (0..15).
  KBD_DEPTH, 8, keyboard FIFO entries (power of two, 2..64).
REQ-002 SHALL have ports (name, direction, width, meaning), one per line; clock and reset come first:
  clk  in  1  single clock; all state updates on the rising edge.
  rst  in  1  asynchronous, active-high reset.
  req  in  1  CPU access request.
  we  in  1  1 = write, 0 = read.
  addr  in  16  CPU virtual byte address.
  wdata  in  DATA_W  write data.
  ready  out  1  one-cycle response strobe.
  rdata  out  DATA_W  read data, valid while ready is high.
  fault  out  1  unmapped or illegal access, valid while ready is high.
  ram_addr  out  16  RAM word address.
  ram_wdata  out  DATA_W  RAM write data.
  ram_we  out  1  RAM write enable.
  ram_oe  out  1  RAM output enable.
  ram_rdata  in  DATA_W  RAM read data.
  rom_addr  out  16  ROM address.
  rom_rdata  in  DATA_W  ROM read data.
  kbd_valid  in  1  keyboard scancode strobe.
  kbd_data  in  DATA_W  scancode.

Function
REQ-003 The decode SHALL select RAM when addr[15]=0, with ram_addr = addr>>1.
REQ-004 The decode SHALL select ROM when addr[15:8]=8'hFF, with rom_addr = {8'h00, addr[7:0]}.
REQ-005 The decode SHALL select KBD_DATA when addr=16'hFE00 and KBD_STAT when addr=16'hFE01; every other address SHALL decode as UNMAPPED.
REQ-006 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-007 In IDLE, when req=1 at an edge, the block SHALL register addr, we and wdata, load wait_cnt with the region wait (KBD and UNMAPPED use 0) and go to ACCESS.
REQ-008 In ACCESS with wait_cnt>0, the block SHALL decrement wait_cnt; with wait_cnt=0 it SHALL capture read data into rdata, set fault and go to RESP.
REQ-009 RESP SHALL assert ready for exactly one cycle and then return to IDLE; req SHALL be ignored outside IDLE.
REQ-010 If req is sampled at edge N, ready SHALL be high between edges N+WAIT+1 and N+WAIT+2.
REQ-011 ram_addr, ram_wdata, ram_we and ram_oe SHALL stay stable for all ACCESS cycles of a RAM access and be deasserted otherwise; ram_we SHALL follow the registered we and ram_oe its inverse.
REQ-012 Writes to ROM, KBD_DATA or UNMAPPED, and any access to UNMAPPED, SHALL give fault=1 and rdata=0 and have no side effect.
REQ-013 A write to KBD_STAT SHALL clear the overflow bit and give fault=0.
REQ-014 The keyboard FIFO SHALL push kbd_data on every cycle that kbd_valid=1 and the FIFO is not full.
REQ-015 A push while the FIFO is full SHALL drop the data and set the sticky overflow bit.
REQ-016 A read of KBD_DATA SHALL return the head entry and pop it at the capture edge; a read while empty SHALL return 0, leave the FIFO unchanged and give fault=0.
REQ-017 A simultaneous push and pop SHALL both take effect and leave the count unchanged; this SHALL hold even when the FIFO is full.
REQ-018 A read of KBD_STAT SHALL return {zero-pad, count[6:0], overflow, full, empty} in bits [9:0] and then clear overflow; an overflow event in that same cycle SHALL win and leave overflow set.
REQ-019 The FIFO pointers SHALL wrap modulo KBD_DEPTH; count SHALL be 0..KBD_DEPTH.

Reset
REQ-020 Asserting rst SHALL immediately force state IDLE, ready=0, rdata=0, fault=0, ram_we=0, ram_oe=0, ram_addr=0, rom_addr=0, ram_wdata=0, FIFO empty and overflow=0.
REQ-021 Reset during ACCESS or RESP SHALL abort the access with no ready pulse and no FIFO pop.
REQ-022 The first request SHALL be accepted at the first edge after rst deasserts.

Structure
REQ-023 Package mem_map_pkg SHALL hold the region enum (RAM, ROM, KBD_DATA, KBD_STAT, UNMAPPED), the FSM state enum and the address constants 16'hFE00, 16'hFE01 and 8'hFF.
REQ-024 The keyboard FIFO SHALL be a sub-module kbd_fifo with parameters DATA_W and DEPTH, and ports push, pop, din, dout, count, full and empty.
REQ-025 Decode SHALL be a pure function placed in mem_map_pkg.

Verification
REQ-026 Read 16'h0010 with RAM_WAIT=1 and ram_rdata=16'hBEEF -> ram_addr=16'h0008, ram_oe high for 2 cycles, ready at N+3, rdata=16'hBEEF, fault=0.
REQ-027 Read 16'hFF2A with ROM_WAIT=0 -> rom_addr=16'h002A, ready at N+2.
REQ-028 Write 16'hFF00 or read 16'hC000 -> fault=1, rdata=0, ram_we never asserted.
REQ-029 Push 9 codes into a depth-8 FIFO, read KBD_STAT, then read KBD_STAT again -> first read count=8, overflow=1, full=1; second read overflow=0.
REQ-030 Read KBD_DATA while kbd_valid pushes in the same cycle on a full FIFO -> head returned, count stays 8, no overflow.
REQ-031 Assert rst during the ACCESS state of a RAM write -> no ready pulse, ram_we=0 immediately, next request serviced normally.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Address map, region/state enums and the pure address decode shared by the
// memory bus controller and anything else that needs to classify CPU addresses.
package mem_map_pkg;

    typedef enum logic [2:0] {
        RAM,
        ROM,
        KBD_DATA,
        KBD_STAT,
        UNMAPPED
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [15:0] KBD_DATA_ADDR = 16'hFE00;
    localparam logic [15:0] KBD_STAT_ADDR = 16'hFE01;
    localparam logic [7:0]  ROM_PAGE      = 8'hFF;

    function automatic region_e decode(input logic [15:0] addr);
        region_e region;
        region = UNMAPPED;
        if (!addr[15]) begin
            region = RAM;
        end else if (addr[15:8] == ROM_PAGE) begin
            region = ROM;
        end else if (addr == KBD_DATA_ADDR) begin
            region = KBD_DATA;
        end else if (addr == KBD_STAT_ADDR) begin
            region = KBD_STAT;
        end
        return region;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard scancode FIFO: power-of-two depth, combinational head output,
// simultaneous push and pop allowed even when full.
module kbd_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_eff;
    logic              pop_eff;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop_eff  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_eff = push && (!full || pop_eff);
    assign dout     = mem[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/memory_bus_ctrl.sv
// CPU memory bus controller: decodes RAM/ROM/keyboard regions, inserts
// per-region wait states and returns a one-cycle ready strobe.
module memory_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RAM_WAIT  = 1,
    parameter int ROM_WAIT  = 0,
    parameter int KBD_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              fault,
    output logic [15:0]       ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_oe,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    input  logic              kbd_valid,
    input  logic [DATA_W-1:0] kbd_data
);
    localparam int CW = $clog2(KBD_DEPTH) + 1;

    state_e            state_q, state_d;
    region_e           region_q, region_d;
    region_e           req_region;
    logic              we_q, we_d;
    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic              ready_q, ready_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_oe_q, ram_oe_d;
    logic [15:0]       rom_addr_q, rom_addr_d;
    logic              ovf_clr;

    logic              capture;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] stat_word;

    assign req_region = decode(addr);
    assign capture    = (state_q == ACCESS) && (wait_q == 4'd0);
    assign fifo_pop   = capture && (region_q == KBD_DATA) && !we_q;

    kbd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (kbd_valid),
        .pop   (fifo_pop),
        .din   (kbd_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        stat_word       = '0;
        stat_word[9:0]  = {7'(fifo_count), overflow_q, fifo_full, fifo_empty};
    end

    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        we_d        = we_q;
        wait_d      = wait_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        ready_d     = ready_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = ram_we_q;
        ram_oe_d    = ram_oe_q;
        rom_addr_d  = rom_addr_q;
        ovf_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                rdata_d = '0;
                fault_d = 1'b0;
                if (req) begin
                    state_d  = ACCESS;
                    region_d = req_region;
                    we_d     = we;
                    wait_d   = 4'd0;
                    if (req_region == RAM) begin
                        wait_d      = 4'(RAM_WAIT);
                        ram_addr_d  = {1'b0, addr[15:1]};
                        ram_wdata_d = wdata;
                        ram_we_d    = we;
                        ram_oe_d    = !we;
                    end else if (req_region == ROM) begin
                        wait_d     = 4'(ROM_WAIT);
                        rom_addr_d = {8'h00, addr[7:0]};
                    end
                end
            end
            ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    state_d     = RESP;
                    ready_d     = 1'b1;
                    rdata_d     = '0;
                    fault_d     = 1'b0;
                    ram_addr_d  = '0;
                    ram_wdata_d = '0;
                    ram_we_d    = 1'b0;
                    ram_oe_d    = 1'b0;
                    rom_addr_d  = '0;
                    case (region_q)
                        RAM: begin
                            if (!we_q) rdata_d = ram_rdata;
                        end
                        ROM: begin
                            if (we_q) fault_d = 1'b1;
                            else      rdata_d = rom_rdata;
                        end
                        KBD_DATA: begin
                            if (we_q)             fault_d = 1'b1;
                            else if (!fifo_empty) rdata_d = fifo_dout;
                        end
                        KBD_STAT: begin
                            if (!we_q) rdata_d = stat_word;
                            ovf_clr = 1'b1;
                        end
                        default: fault_d = 1'b1;
                    endcase
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b0;
                rdata_d = '0;
                fault_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A dropped push in the clearing cycle must leave overflow set.
        overflow_d = ovf_clr ? 1'b0 : overflow_q;
        if (kbd_valid && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            region_q    <= UNMAPPED;
            we_q        <= 1'b0;
            wait_q      <= 4'd0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            rom_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            ready_q     <= ready_d;
            overflow_q  <= overflow_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            rom_addr_q  <= rom_addr_d;
        end
    end

    assign ready     = ready_q;
    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;
    assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_memory_bus_ctrl.sv
// Directed bench for memory_bus_ctrl: RAM/ROM/keyboard accesses, faults,
// FIFO overflow and wrap, and reset in the middle of an access.
module tb_memory_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        ready;
    logic [15:0] rdata;
    logic        fault;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        ram_oe;
    logic [15:0] ram_rdata = 16'hBEEF;
    logic [15:0] rom_addr;
    logic [15:0] rom_rdata;
    logic        kbd_valid = 1'b0;
    logic [15:0] kbd_data = '0;

    int checks = 0;
    int errors = 0;

    // ROM stand-in: a fixed high byte over the addressed low byte.
    assign rom_rdata = {8'hA5, rom_addr[7:0]};

    always #5 clk = ~clk;

    memory_bus_ctrl #(
        .DATA_W    (16),
        .RAM_WAIT  (1),
        .ROM_WAIT  (0),
        .KBD_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .fault     (fault),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_rdata (ram_rdata),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    // One complete bus transaction; latency counts edges from accept to ready rise.
    task automatic bus_access(input logic w, input logic [15:0] a, input logic [15:0] wd,
                              output logic [15:0] rd, output logic flt, output int lat,
                              output int oe_cyc, output int we_cyc,
                              output logic [15:0] ram_a, output logic [15:0] ram_wd,
                              output logic [15:0] rom_a);
        rd = '0; flt = 1'b0; lat = -1; oe_cyc = 0; we_cyc = 0;
        ram_a = '0; ram_wd = '0; rom_a = '0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (ram_oe) oe_cyc++;
            if (ram_we) we_cyc++;
            if (ram_oe || ram_we) begin
                ram_a  = ram_addr;
                ram_wd = ram_wdata;
            end
            if (rom_addr != 16'h0000) rom_a = rom_addr;
            if (ready) begin
                lat = j;
                rd  = rdata;
                flt = fault;
                break;
            end
        end
        if (lat < 0) check("ready_timeout", 32'd0, 32'd1);
        $display("access we=%0b addr=%h -> rdata=%h fault=%0b lat=%0d", w, a, rd, flt, lat);
    endtask

    task automatic read_word(input logic [15:0] a, output logic [15:0] rd, output logic flt);
        int lat, oc, wc;
        logic [15:0] ra, rw, ro;
        bus_access(1'b0, a, 16'h0000, rd, flt, lat, oc, wc, ra, rw, ro);
    endtask

    task automatic push_codes(input int n, input logic [15:0] base);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            kbd_valid = 1'b1;
            kbd_data  = base + 16'(i);
            @(negedge clk);
        end
        kbd_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] rd, ra, rw, ro;
        logic        flt;
        int          lat, oc, wc, ready_seen;
        logic [15:0] exp_codes [8];

        #2;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_oe", 32'(ram_oe), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        read_word(16'hFE01, rd, flt);
        check("stat_empty", 32'(rd), 32'h0001);
        read_word(16'hFE00, rd, flt);
        check("kbd_empty_rdata", 32'(rd), 32'h0000);
        check("kbd_empty_fault", 32'(flt), 32'd0);

        bus_access(1'b0, 16'h0010, 16'h0000, rd, flt, lat, oc, wc, ra, rw, ro);
        check("ram_rd_rdata", 32'(rd), 32'hBEEF);
        check("ram_rd_fault", 32'(flt), 32'd0);
        check("ram_rd_lat", 32'(lat), 32'd2);
        check("ram_rd_oe_cyc", 32'(oc), 32'd2);
        check("ram_rd_we_cyc", 32'(wc), 32'd0);
        check("ram_rd_addr", 32'(ra), 32'h0008);

        bus_access(1'b1, 16'h0010, 16'h1234, rd, flt, lat, oc, wc, ra, rw, ro);
        check("ram_wr_fault", 32'(flt), 32'd0);
        check("ram_wr_we_cyc", 32'(wc), 32'd2);
        check("ram_wr_oe_cyc", 32'(oc), 32'd0);
        check("ram_wr_wdata", 32'(rw), 32'h1234);
        check("ram_wr_lat", 32'(lat), 32'd2);

        bus_access(1'b0, 16'hFF2A, 16'h0000, rd, flt, lat, oc, wc, ra, rw, ro);
        check("rom_addr", 32'(ro), 32'h002A);
        check("rom_rdata", 32'(rd), 32'hA52A);
        check("rom_lat", 32'(lat), 32'd1);
        check("rom_fault", 32'(flt), 32'd0);

        bus_access(1'b1, 16'hFF00, 16'hAAAA, rd, flt, lat, oc, wc, ra, rw, ro);
        check("rom_wr_fault", 32'(flt), 32'd1);
        check("rom_wr_rdata", 32'(rd), 32'h0000);
        check("rom_wr_we_cyc", 32'(wc), 32'd0);

        bus_access(1'b0, 16'hC000, 16'h0000, rd, flt, lat, oc, wc, ra, rw, ro);
        check("unmap_fault", 32'(flt), 32'd1);
        check("unmap_rdata", 32'(rd), 32'h0000);
        check("unmap_oe_cyc", 32'(oc), 32'd0);

        bus_access(1'b1, 16'hFE00, 16'h0055, rd, flt, lat, oc, wc, ra, rw, ro);
        check("kbd_wr_fault", 32'(flt), 32'd1);

        // Nine pushes into eight slots: last code dropped, overflow set.
        push_codes(9, 16'h0011);
        read_word(16'hFE01, rd, flt);
        check("stat_ovf", 32'(rd), 32'h0046);
        read_word(16'hFE01, rd, flt);
        check("stat_ovf_clr", 32'(rd), 32'h0042);

        // Pop and push in the same capture edge on a full FIFO.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'hFE00;
        @(posedge clk);
        #1 req = 1'b0; kbd_valid = 1'b1; kbd_data = 16'h002A;
        @(posedge clk);
        #1 kbd_valid = 1'b0;
        @(negedge clk);
        check("pushpop_ready", 32'(ready), 32'd1);
        check("pushpop_head", 32'(rdata), 32'h0011);
        read_word(16'hFE01, rd, flt);
        check("pushpop_stat", 32'(rd), 32'h0042);

        exp_codes = '{16'h0012, 16'h0013, 16'h0014, 16'h0015,
                      16'h0016, 16'h0017, 16'h0018, 16'h002A};
        for (int i = 0; i < 8; i++) begin
            read_word(16'hFE00, rd, flt);
            check($sformatf("drain_%0d", i), 32'(rd), 32'(exp_codes[i]));
        end
        read_word(16'hFE01, rd, flt);
        check("stat_drained", 32'(rd), 32'h0001);

        push_codes(9, 16'h0030);
        bus_access(1'b1, 16'hFE01, 16'h0000, rd, flt, lat, oc, wc, ra, rw, ro);
        check("stat_wr_fault", 32'(flt), 32'd0);
        read_word(16'hFE01, rd, flt);
        check("stat_wr_clr", 32'(rd), 32'h0042);

        // Reset in the middle of a RAM write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h5555;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("abort_we_before", 32'(ram_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_we_after", 32'(ram_we), 32'd0);
        ready_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready) ready_seen++;
        end
        check("abort_no_ready", 32'(ready_seen), 32'd0);
        rst = 1'b0;
        bus_access(1'b0, 16'h0010, 16'h0000, rd, flt, lat, oc, wc, ra, rw, ro);
        check("post_rst_rdata", 32'(rd), 32'hBEEF);
        check("post_rst_lat", 32'(lat), 32'd2);
        read_word(16'hFE01, rd, flt);
        check("post_rst_stat", 32'(rd), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
